// File: rtl/read_counter.sv
// rtl/read_counter.sv - CDU read counter with rate-divided stepping and switch-drive decode
module read_counter #(
    parameter int RATE_DIV   = 8,
    parameter int SETTLE_CYC = 4,
    parameter int COARSE_RUN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        czero,
    input  logic        err_up,
    input  logic        err_dn,
    output logic [15:0] rc,
    output logic        cdu_plus,
    output logic        cdu_minus,
    output logic        coarse,
    output logic        _D1,
    output logic        _D2,
    output logic        _D3,
    output logic        _D4,
    output logic        _D5,
    output logic        _D6,
    output logic        _D7,
    output logic        _D8,
    output logic        _D9,
    output logic        _D10,
    output logic        _D11,
    output logic        _D12,
    output logic        _D13,
    output logic        _D14
);

    localparam int DIV_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
    localparam int RUN_W = $clog2(COARSE_RUN + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_UP = 2'd1,
        RUN_DN = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [RUN_W-1:0] r_run_cnt;
    logic [SET_W-1:0] r_set_cnt;
    logic [15:0]      r_rc;
    logic             r_plus;
    logic             r_minus;
    logic             r_coarse;
    logic [14:1]      r_d;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [SET_W-1:0] w_set_nxt;
    logic [15:0]      w_rc_nxt;
    logic             w_plus_nxt;
    logic             w_minus_nxt;
    logic             w_coarse_nxt;
    logic             w_up;
    logic             w_dn;
    logic             w_same;
    logic             w_opp;

    // Switch-drive pattern for a counter value and mode (active-low drives)
    function automatic logic [14:1] f_decode(input logic [15:0] q, input logic c);
        logic [14:1] d;
        logic [1:0]  k;
        k       = q[14] ? ~q[13:12] : q[13:12];
        d[4:1]  = ~(4'b0001 << k);
        d[5]    = q[15];
        d[6]    = 1'b1;
        d[7]    = q[15] ^ q[14];
        d[8]    = 1'b1;
        d[9]    = ~c;
        d[10]   = c;
        d[11]   = q[11];
        d[12]   = ~c;
        d[13]   = c;
        d[14]   = ~q[11];
        return d;
    endfunction

    assign w_up   = err_up & ~err_dn;
    assign w_dn   = err_dn & ~err_up;
    assign w_same = (r_state == RUN_UP) ? w_up : w_dn;
    assign w_opp  = (r_state == RUN_UP) ? w_dn : w_up;

    // Next-state and next-output computation; czero overrides any pending step
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_run_nxt   = r_run_cnt;
        w_set_nxt   = r_set_cnt;
        w_rc_nxt    = r_rc;
        w_plus_nxt  = 1'b0;
        w_minus_nxt = 1'b0;
        if (czero) begin
            w_state_nxt = IDLE;
            w_rc_nxt    = 16'd0;
            w_div_nxt   = '0;
            w_run_nxt   = '0;
            w_set_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_div_nxt = '0;
                    w_run_nxt = '0;
                    if (w_up) begin
                        w_state_nxt = RUN_UP;
                    end else if (w_dn) begin
                        w_state_nxt = RUN_DN;
                    end
                end
                RUN_UP, RUN_DN: begin
                    if (w_opp) begin
                        w_state_nxt = SETTLE;
                        w_set_nxt   = SET_W'(SETTLE_CYC);
                        w_div_nxt   = '0;
                        w_run_nxt   = '0;
                    end else if (!w_same) begin
                        w_state_nxt = IDLE;
                        w_div_nxt   = '0;
                        w_run_nxt   = '0;
                    end else if (r_div_cnt == DIV_W'(RATE_DIV - 1)) begin
                        w_div_nxt = '0;
                        if (r_run_cnt != RUN_W'(COARSE_RUN)) begin
                            w_run_nxt = r_run_cnt + RUN_W'(1);
                        end
                        if (r_state == RUN_UP) begin
                            w_rc_nxt   = r_rc + 16'd1;
                            w_plus_nxt = 1'b1;
                        end else begin
                            w_rc_nxt    = r_rc - 16'd1;
                            w_minus_nxt = 1'b1;
                        end
                    end else begin
                        w_div_nxt = r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    w_run_nxt = '0;
                    if (r_set_cnt <= SET_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_set_nxt   = '0;
                    end else begin
                        w_set_nxt = r_set_cnt - SET_W'(1);
                    end
                end
            endcase
        end
        w_coarse_nxt = (w_run_nxt == RUN_W'(COARSE_RUN));
    end

    // State, counter and all outputs registered together so decode has no extra latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_run_cnt <= '0;
            r_set_cnt <= '0;
            r_rc      <= 16'd0;
            r_plus    <= 1'b0;
            r_minus   <= 1'b0;
            r_coarse  <= 1'b0;
            r_d       <= f_decode(16'd0, 1'b0);
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_nxt;
            r_run_cnt <= w_run_nxt;
            r_set_cnt <= w_set_nxt;
            r_rc      <= w_rc_nxt;
            r_plus    <= w_plus_nxt;
            r_minus   <= w_minus_nxt;
            r_coarse  <= w_coarse_nxt;
            r_d       <= f_decode(w_rc_nxt, w_coarse_nxt);
        end
    end

    assign rc        = r_rc;
    assign cdu_plus  = r_plus;
    assign cdu_minus = r_minus;
    assign coarse    = r_coarse;
    assign _D1       = r_d[1];
    assign _D2       = r_d[2];
    assign _D3       = r_d[3];
    assign _D4       = r_d[4];
    assign _D5       = r_d[5];
    assign _D6       = r_d[6];
    assign _D7       = r_d[7];
    assign _D8       = r_d[8];
    assign _D9       = r_d[9];
    assign _D10      = r_d[10];
    assign _D11      = r_d[11];
    assign _D12      = r_d[12];
    assign _D13      = r_d[13];
    assign _D14      = r_d[14];

endmodule
